// File: rtl/led_shifter_receiver_pkg.sv
// Shared definitions for the serial LED-shifter link receiver.
package led_shifter_receiver_pkg;

  // Receiver FSM encodings (2 bits, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  // One 74HC595-style 8-bit shifter per frame
  localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/led_shifter_receiver_sync_edge_detect.sv
// 2-FF synchronizer with optional rising-edge detect via a third delay flop.
module led_shifter_receiver_sync_edge_detect #(
  parameter bit HasRise = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic s1_q, s2_q;

  // Two-stage synchronizer for an input asynchronous to i_clk
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= i_async;
      s2_q <= s1_q;
    end
  end

  assign o_level = s2_q;

  if (HasRise) begin : g_rise
    logic s3_q;

    // Delay flop so a rise is seen for exactly one cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        s3_q <= 1'b0;
      end else begin
        s3_q <= s2_q;
      end
    end

    assign o_rise = s2_q & ~s3_q;
  end else begin : g_no_rise
    assign o_rise = 1'b0;
  end

endmodule

// File: rtl/led_shifter_receiver.sv
// Receiver for the ds/cp/mr_n LED-shifter link: shifts ds in MSB-first on each cp rise and
// emits one parallel word per DATA_WIDTH bits, aborting stalled partial frames.
module led_shifter_receiver
  import led_shifter_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TIMEOUT_WIDTH  = 11
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_shifter_ds,
  input  logic                  i_shifter_cp,
  input  logic                  i_shifter_mr_n,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_error
);

  localparam int unsigned CountWidth = $clog2(DATA_WIDTH + 1);
  localparam logic [CountWidth-1:0]    CountLast   = CountWidth'(DATA_WIDTH - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLast = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic ds_level, cp_rise, mr_n_level;
  logic cp_level_unused, ds_rise_unused, mr_rise_unused;

  led_shifter_receiver_sync_edge_detect #(.HasRise(1'b1)) u_sync_cp (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_shifter_cp),
    .o_level   (cp_level_unused),
    .o_rise    (cp_rise)
  );

  led_shifter_receiver_sync_edge_detect #(.HasRise(1'b0)) u_sync_ds (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_shifter_ds),
    .o_level   (ds_level),
    .o_rise    (ds_rise_unused)
  );

  led_shifter_receiver_sync_edge_detect #(.HasRise(1'b0)) u_sync_mr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_shifter_mr_n),
    .o_level   (mr_n_level),
    .o_rise    (mr_rise_unused)
  );

  logic [1:0]               state_q, state_d;
  logic [CountWidth-1:0]    count_q, count_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]    sr_q, sr_d, sr_shift;
  logic [DATA_WIDTH:0]      shift_ext;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     valid_q, valid_d, err_q, err_d;

  // Widened concat keeps the shift legal for DATA_WIDTH == 1
  assign shift_ext = {sr_q, ds_level};
  assign sr_shift  = shift_ext[DATA_WIDTH-1:0];

  // Next-state: mr_n low beats cp_rise, which beats the timeout
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (!mr_n_level) begin
      state_d = ST_CLEAR;
      sr_d    = '0;
      count_d = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        ST_CLEAR: state_d = ST_IDLE;
        ST_IDLE, ST_SHIFT: begin
          if (cp_rise) begin
            tmo_d = '0;
            sr_d  = sr_shift;
            if (count_q == CountLast) begin
              data_d  = sr_shift;
              valid_d = 1'b1;
              count_d = '0;
              state_d = ST_IDLE;
            end else begin
              count_d = count_q + CountWidth'(1);
              state_d = ST_SHIFT;
            end
          end else if (state_q == ST_SHIFT) begin
            if (tmo_q == TimeoutLast) begin
              err_d   = 1'b1;
              count_d = '0;
              sr_d    = '0;
              tmo_d   = '0;
              state_d = ST_IDLE;
            end else begin
              tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tmo_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_error = err_q;

endmodule

// File: tb/tb_led_shifter_receiver.sv
// Directed bench for led_shifter_receiver with an expected-frame queue.
module tb_led_shifter_receiver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ds = 1'b0, cp = 1'b0, mr_n = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_error;

  always #5 clk = ~clk;

  led_shifter_receiver #(
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_WIDTH  (5)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_shifter_ds   (ds),
    .i_shifter_cp   (cp),
    .i_shifter_mr_n (mr_n),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_frame_error  (o_frame_error)
  );

  int         checks = 0, errors = 0;
  int         cyc = 0, n_valid = 0, n_err = 0;
  int         last_valid_cyc = 0, last_err_cyc = 0, rise_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (o_valid || o_frame_error) begin
      check("pulse_exclusive", {31'b0, o_valid & o_frame_error}, 32'd0);
      check("pulse_not_consecutive", {31'b0, prev_pulse}, 32'd0);
    end
    if (o_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      check("expected_frame_pending", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("o_data", {24'b0, o_data}, {24'b0, e});
        last_good = e;
      end
    end
    if (o_frame_error) begin
      n_err++;
      last_err_cyc = cyc;
    end
    prev_pulse = o_valid | o_frame_error;
  endtask

  // One cp period: 4 cycles low (ds set), then high_cycles high
  task automatic send_bit(input logic b, input int high_cycles);
    cp = 1'b0;
    ds = b;
    repeat (4) step();
    cp = 1'b1;
    rise_cyc = cyc;
    repeat (high_cycles) step();
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[7-i], 4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    exp_q.push_back(v);
    send_bits(v, 8);
  endtask

  task automatic idle(input int n);
    cp = 1'b0;
    repeat (n) step();
  endtask

  int v0, e0, v1, rc, d;

  initial begin
    // 1. Reset with random inputs, then quiet link
    for (int i = 0; i < 6; i++) begin
      ds   = 1'($urandom_range(0, 1));
      cp   = 1'($urandom_range(0, 1));
      mr_n = 1'($urandom_range(0, 1));
      step();
      check("reset_o_data", {24'b0, o_data}, 32'd0);
      check("reset_pulses", {30'b0, o_valid, o_frame_error}, 32'd0);
    end
    ds = 1'b0; cp = 1'b0; mr_n = 1'b1;
    reset_n = 1'b1;
    repeat (100) step();
    check("idle_no_valid", n_valid, 0);
    check("idle_no_error", n_err, 0);

    // 2. Single frame with latency check
    send_byte(8'hA5);
    check("a5_latency", last_valid_cyc - rise_cyc, 3);
    idle(8);
    check("a5_one_valid", n_valid, 1);
    check("a5_no_error", n_err, 0);

    // 3. Back-to-back frames
    send_byte(8'h3C);
    v1 = last_valid_cyc;
    send_byte(8'hC3);
    check("b2b_spacing", last_valid_cyc - v1, 64);
    idle(8);
    check("b2b_count", n_valid, 3);

    // 4a. mr_n clears a partial frame
    send_bits(8'hE0, 3);
    cp = 1'b0; mr_n = 1'b0;
    repeat (4) step();
    mr_n = 1'b1;
    repeat (4) step();
    send_byte(8'h81);
    idle(8);
    check("mr_clear_valid", n_valid, 4);
    check("mr_clear_no_error", n_err, 0);

    // 4b. mr_n low coincident with the completing rise
    send_bits(8'h7E, 7);
    cp = 1'b0; ds = 1'b0;
    repeat (4) step();
    cp = 1'b1; mr_n = 1'b0;
    repeat (4) step();
    cp = 1'b0; mr_n = 1'b1;
    repeat (8) step();
    check("mr_coincident_no_valid", n_valid, 4);
    check("mr_coincident_data_held", {24'b0, o_data}, {24'b0, last_good});

    // 5. Timeout on a stalled partial frame
    e0 = n_err;
    send_bits(8'hFF, 5);
    rc = rise_cyc;
    idle(20);
    check("timeout_one_error", n_err - e0, 1);
    d = last_err_cyc - rc;
    check("timeout_window", {31'b0, (d >= 14) && (d <= 22)}, 32'd1);
    check("timeout_data_held", {24'b0, o_data}, {24'b0, last_good});
    check("timeout_no_valid", n_valid, 4);
    send_byte(8'h5A);
    idle(8);
    check("after_timeout_valid", n_valid, 5);

    // 6a. cp held high on the final bit shifts once
    v0 = n_valid; e0 = n_err;
    exp_q.push_back(8'h96);
    send_bits(8'h96, 7);
    send_bit(1'b0, 100);
    idle(8);
    check("long_high_one_valid", n_valid - v0, 1);
    check("long_high_no_error", n_err - e0, 0);

    // 6b. Async reset mid-frame
    send_bits(8'hF0, 4);
    reset_n = 1'b0;
    #1;
    check("async_reset_data", {24'b0, o_data}, 32'd0);
    check("async_reset_pulses", {30'b0, o_valid, o_frame_error}, 32'd0);
    last_good = 8'h00;
    repeat (3) step();
    cp = 1'b0;
    reset_n = 1'b1;
    repeat (4) step();
    v0 = n_valid;
    send_byte(8'h12);
    idle(8);
    check("post_reset_valid", n_valid - v0, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
